// File: rtl/vend_panel_arbiter.sv
// Two-panel front end for a single vending core: grants one panel at a time,
// forwards its coin code, captures the core's result, and counts vends per panel.
module vend_panel_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int DRAIN   = 2,
  parameter int CNT_W   = 8
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [1:0]       coin_a,
  input  logic             req_b,
  input  logic [1:0]       coin_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [1:0]       vm_in,
  input  logic             vm_out,
  input  logic [1:0]       vm_change,
  output logic             vend_a,
  output logic             vend_b,
  output logic [1:0]       chg_a,
  output logic [1:0]       chg_b,
  output logic             tmo,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SESSION = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  localparam int TW = $clog2(TIMEOUT);
  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  logic [1:0]       state_q, state_d;
  logic             own_q, own_d;        // 0 = panel A, 1 = panel B
  logic             last_q, last_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic             credited_q, credited_d;
  logic             gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic             vend_a_q, vend_a_d, vend_b_q, vend_b_d;
  logic [1:0]       chg_a_q, chg_a_d, chg_b_q, chg_b_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  logic       done, req_own, credit;
  logic [1:0] coin_own;

  assign done     = vm_out | (vm_change != 2'b00);
  assign req_own  = own_q ? req_b  : req_a;
  assign coin_own = own_q ? coin_b : coin_a;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    own_d       = own_q;
    last_d      = last_q;
    tmo_cnt_d   = tmo_cnt_q;
    drain_cnt_d = drain_cnt_q;
    credited_d  = credited_q;
    gnt_a_d     = gnt_a_q;
    gnt_b_d     = gnt_b_q;
    vend_a_d    = 1'b0;
    vend_b_d    = 1'b0;
    chg_a_d     = chg_a_q;
    chg_b_d     = chg_b_q;
    tmo_d       = 1'b0;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    credit      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_a | req_b) begin
          own_d      = (req_a & req_b) ? ~last_q : req_b;
          state_d    = S_SESSION;
          tmo_cnt_d  = '0;
          credited_d = 1'b0;
          gnt_a_d    = ~own_d;
          gnt_b_d    = own_d;
        end
      end
      S_SESSION: begin
        // Completion beats cancel, cancel beats timeout.
        if (done) begin
          credit      = 1'b1;
          credited_d  = 1'b1;
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end else if (!req_own) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end else if (coin_own != 2'b00) begin
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          tmo_d       = 1'b1;
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // A late refund after cancel/timeout is credited once to the owner.
        if (done && !credited_q) begin
          credit     = 1'b1;
          credited_d = 1'b1;
        end
        if (drain_cnt_q == DW'(DRAIN - 1)) begin
          state_d = S_IDLE;
          gnt_a_d = 1'b0;
          gnt_b_d = 1'b0;
          last_d  = own_q;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (credit) begin
      if (!own_q) begin
        chg_a_d  = vm_change;
        vend_a_d = vm_out;
        if (vm_out && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + 1'b1;
      end else begin
        chg_b_d  = vm_change;
        vend_b_d = vm_out;
        if (vm_out && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      own_q       <= 1'b0;
      last_q      <= 1'b1;
      tmo_cnt_q   <= '0;
      drain_cnt_q <= '0;
      credited_q  <= 1'b0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      vend_a_q    <= 1'b0;
      vend_b_q    <= 1'b0;
      chg_a_q     <= 2'b00;
      chg_b_q     <= 2'b00;
      tmo_q       <= 1'b0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      last_q      <= last_d;
      tmo_cnt_q   <= tmo_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      credited_q  <= credited_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      vend_a_q    <= vend_a_d;
      vend_b_q    <= vend_b_d;
      chg_a_q     <= chg_a_d;
      chg_b_q     <= chg_b_d;
      tmo_q       <= tmo_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
    end
  end

  assign vm_in  = (state_q == S_SESSION) ? coin_own : 2'b00;
  assign busy   = (state_q != S_IDLE);
  assign gnt_a  = gnt_a_q;
  assign gnt_b  = gnt_b_q;
  assign vend_a = vend_a_q;
  assign vend_b = vend_b_q;
  assign chg_a  = chg_a_q;
  assign chg_b  = chg_b_q;
  assign tmo    = tmo_q;
  assign cnt_a  = cnt_a_q;
  assign cnt_b  = cnt_b_q;

endmodule

// File: tb/tb_vend_panel_arbiter.sv
// Bench for vend_panel_arbiter: vector table, directed corner sequences, and
// randomized traffic checked against a session-level reference model.
module tb_vend_panel_arbiter;

  localparam int TIMEOUT = 16;
  localparam int DRAIN   = 2;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             rst;
  logic             req_a, req_b, vm_out;
  logic [1:0]       coin_a, coin_b, vm_change;
  logic             gnt_a, gnt_b, vend_a, vend_b, tmo, busy;
  logic [1:0]       vm_in, chg_a, chg_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  vend_panel_arbiter #(.TIMEOUT(TIMEOUT), .DRAIN(DRAIN), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .rst(rst),
    .req_a(req_a), .coin_a(coin_a), .req_b(req_b), .coin_b(coin_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .vm_in(vm_in),
    .vm_out(vm_out), .vm_change(vm_change),
    .vend_a(vend_a), .vend_b(vend_b), .chg_a(chg_a), .chg_b(chg_b),
    .tmo(tmo), .cnt_a(cnt_a), .cnt_b(cnt_b), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: owner -1 means nobody holds the core.
  int         m_owner, m_drain_left, m_zero_run, m_last;
  bit         m_sess, m_credited, m_tmo;
  bit         m_vend[2];
  logic [1:0] m_chg[2];
  int         m_cnt[2];

  task automatic model_reset();
    m_owner = -1; m_sess = 0; m_drain_left = 0; m_zero_run = 0; m_last = 1;
    m_credited = 0; m_tmo = 0;
    for (int p = 0; p < 2; p++) begin
      m_vend[p] = 0; m_chg[p] = 2'b00; m_cnt[p] = 0;
    end
  endtask

  function automatic logic [1:0] model_vm_in();
    if (m_owner >= 0 && m_sess) return (m_owner == 0) ? coin_a : coin_b;
    return 2'b00;
  endfunction

  task automatic model_credit();
    if (vm_out) begin
      m_vend[m_owner] = 1;
      if (m_cnt[m_owner] < CNT_MAX) m_cnt[m_owner]++;
    end
    m_chg[m_owner] = vm_change;
  endtask

  task automatic model_step();
    bit         rq[2];
    logic [1:0] cn[2];
    bit         done;
    rq[0] = req_a; rq[1] = req_b; cn[0] = coin_a; cn[1] = coin_b;
    done = vm_out || (vm_change != 2'b00);
    m_vend[0] = 0; m_vend[1] = 0; m_tmo = 0;
    if (m_owner < 0) begin
      if (rq[0] || rq[1]) begin
        m_owner = (rq[0] && rq[1]) ? 1 - m_last : (rq[0] ? 0 : 1);
        m_sess = 1; m_zero_run = 0; m_credited = 0;
      end
    end else if (m_sess) begin
      if (done) begin
        model_credit(); m_credited = 1; m_sess = 0; m_drain_left = DRAIN;
      end else if (!rq[m_owner]) begin
        m_sess = 0; m_drain_left = DRAIN;
      end else if (cn[m_owner] != 2'b00) begin
        m_zero_run = 0;
      end else begin
        m_zero_run++;
        if (m_zero_run == TIMEOUT) begin
          m_tmo = 1; m_sess = 0; m_drain_left = DRAIN;
        end
      end
    end else begin
      if (done && !m_credited) begin
        model_credit(); m_credited = 1;
      end
      m_drain_left--;
      if (m_drain_left == 0) begin
        m_last = m_owner; m_owner = -1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_a = 0; req_b = 0; coin_a = 0; coin_b = 0; vm_out = 0; vm_change = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge Clk);
    #1 rst = 0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, " gnt_a"},  gnt_a,  m_owner == 0);
    check({tag, " gnt_b"},  gnt_b,  m_owner == 1);
    check({tag, " busy"},   busy,   m_owner >= 0);
    check({tag, " vend_a"}, vend_a, m_vend[0]);
    check({tag, " vend_b"}, vend_b, m_vend[1]);
    check({tag, " chg_a"},  chg_a,  m_chg[0]);
    check({tag, " chg_b"},  chg_b,  m_chg[1]);
    check({tag, " tmo"},    tmo,    m_tmo);
    check({tag, " cnt_a"},  cnt_a,  m_cnt[0]);
    check({tag, " cnt_b"},  cnt_b,  m_cnt[1]);
  endtask

  typedef struct {
    logic       ra;
    logic [1:0] ca;
    logic       rb;
    logic [1:0] cb;
    logic       vo;
    logic [1:0] vc;
    logic [1:0] e_vm;
    logic       e_ga;
    logic       e_gb;
    logic       e_vend;
    logic [1:0] e_chg;
    logic [7:0] e_cnt;
    logic       e_busy;
  } vec_t;

  vec_t vecs[17];

  initial begin
    // inputs: ra ca rb cb vo vc | expected: vm_in(pre-edge) gnt_a gnt_b vend_a chg_a cnt_a busy
    vecs[0]  = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1};
    vecs[1]  = '{1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 2'd1, 8'd1, 1'b1};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1, 1'b1};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd1, 1'b0};
    vecs[6]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd1, 1'b0};
    vecs[7]  = '{1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd1, 8'd1, 1'b1};
    vecs[8]  = '{1'b1, 2'd2, 1'b1, 2'd1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 2'd1, 8'd1, 1'b1};
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd1, 8'd1, 1'b1};
    vecs[10] = '{1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd1, 8'd1, 1'b1};
    vecs[11] = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd1, 1'b0};
    vecs[12] = '{1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1, 1'b1};
    vecs[13] = '{1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1, 1'b1};
    vecs[14] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1, 1'b1};
    vecs[15] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1, 1'b1};
    vecs[16] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd1, 1'b0};

    do_reset();
    check("reset gnt_a", gnt_a, 0);
    check("reset gnt_b", gnt_b, 0);
    check("reset vm_in", vm_in, 0);
    check("reset busy",  busy,  0);
    check("reset cnt_a", cnt_a, 0);
    check("reset chg_a", chg_a, 0);

    // Single vend, tie after a completed session, cancel, coin 11 forwarding.
    for (int i = 0; i < 17; i++) begin
      req_a = vecs[i].ra; coin_a = vecs[i].ca; req_b = vecs[i].rb; coin_b = vecs[i].cb;
      vm_out = vecs[i].vo; vm_change = vecs[i].vc;
      #1;
      check($sformatf("v%0d vm_in", i), vm_in, vecs[i].e_vm);
      tick();
      check($sformatf("v%0d gnt_a", i),  gnt_a,  vecs[i].e_ga);
      check($sformatf("v%0d gnt_b", i),  gnt_b,  vecs[i].e_gb);
      check($sformatf("v%0d vend_a", i), vend_a, vecs[i].e_vend);
      check($sformatf("v%0d chg_a", i),  chg_a,  vecs[i].e_chg);
      check($sformatf("v%0d cnt_a", i),  cnt_a,  vecs[i].e_cnt);
      check($sformatf("v%0d busy", i),   busy,   vecs[i].e_busy);
    end

    // Round-robin: tie after reset goes to A, B waits DRAIN+1 cycles, next tie goes to A.
    do_reset();
    req_a = 1; req_b = 1; tick();
    check("rr tie0 gnt_a", gnt_a, 1);
    check("rr tie0 gnt_b", gnt_b, 0);
    req_a = 0; tick(); tick();
    check("rr drain gnt_a", gnt_a, 1);
    tick();
    check("rr idle gap gnt_b", gnt_b, 0);
    tick();
    check("rr b granted", gnt_b, 1);
    req_b = 0; tick();
    req_a = 1; req_b = 1; tick(); tick();
    check("rr b released", gnt_b, 0);
    tick();
    check("rr tie1 gnt_a", gnt_a, 1);
    check("rr tie1 gnt_b", gnt_b, 0);

    // Timeout: 16 idle coin cycles inside B's session.
    do_reset();
    req_b = 1; tick();
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      check($sformatf("tmo cyc%0d", i), tmo, i == TIMEOUT - 1);
    end
    check("tmo drain gnt_b", gnt_b, 1);
    tick();
    check("tmo one-shot", tmo, 0);
    tick();
    check("tmo released gnt_b", gnt_b, 0);
    check("tmo cnt_b", cnt_b, 0);
    req_b = 0; tick();

    // Cancel followed by a refund seen during DRAIN.
    do_reset();
    req_a = 1; tick();
    coin_a = 2'b01; tick();
    req_a = 0; coin_a = 0; tick();
    check("cancel drain gnt_a", gnt_a, 1);
    vm_change = 2'b01; tick();
    check("refund chg_a",  chg_a,  2'b01);
    check("refund vend_a", vend_a, 0);
    check("refund cnt_a",  cnt_a,  0);
    vm_change = 0; tick();
    check("refund released", gnt_a, 0);

    // Asynchronous reset in the middle of a session.
    do_reset();
    req_a = 1; tick();
    vm_out = 1; tick();
    vm_out = 0; tick(); tick(); tick();
    coin_a = 2'b10; #1;
    check("pre-rst vm_in", vm_in, 2'b10);
    check("pre-rst cnt_a", cnt_a, 1);
    #2 rst = 1;
    #1;
    check("async rst gnt_a", gnt_a, 0);
    check("async rst vm_in", vm_in, 0);
    check("async rst cnt_a", cnt_a, 0);
    check("async rst busy",  busy,  0);
    do_reset();

    // Counter saturation at all-ones.
    req_a = 1;
    for (int i = 0; i <= CNT_MAX; i++) begin
      tick();
      vm_out = 1; tick();
      if (i == CNT_MAX - 1) check("sat cnt_a 255th", cnt_a, CNT_MAX);
      if (i == CNT_MAX) begin
        check("sat cnt_a 256th",  cnt_a,  CNT_MAX);
        check("sat vend_a pulse", vend_a, 1);
      end
      vm_out = 0; tick(); tick();
    end
    req_a = 0; tick(); tick();

    // Randomized traffic against the reference model.
    do_reset();
    begin
      bit quiet = 0;
      for (int c = 0; c < 4000; c++) begin
        if (c % 64 == 0) quiet = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 5) == 0) req_a = ~req_a;
        if ($urandom_range(0, 5) == 0) req_b = ~req_b;
        coin_a = quiet ? 2'b00 : 2'($urandom_range(0, 3));
        coin_b = quiet ? 2'b00 : 2'($urandom_range(0, 3));
        if (!quiet && $urandom_range(0, 9) == 0) begin
          vm_out = 1'($urandom_range(0, 1));
          vm_change = 2'($urandom_range(0, 3));
        end else begin
          vm_out = 0; vm_change = 0;
        end
        #1;
        check("rand vm_in", vm_in, model_vm_in());
        tick();
        compare_model("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
